// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vc_fifo
//  Description : Multi-channel circular FIFO for NoC router input ports.
//                VC_NUM independent queues of 2**FIFO_DEPTH_W flits each,
//                per-VC fill counts and status flags, sticky per-VC
//                overflow/underflow, registered or first-word-fall-through
//                read data.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_fifo #(
    parameter int DATA_W                 = 8,
    parameter int FIFO_DEPTH_W           = 2,
    parameter int VC_NUM                 = 2,
    parameter int VC_W                   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int FWFT                   = 0,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    parameter int ALMOST_FULL_THRESHOLD  = 3,
    parameter int ID                     = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                wr_en_i,
    input  logic [VC_W-1:0]                     wr_vc_i,
    input  logic [DATA_W-1:0]                   data_i,
    input  logic                                rd_en_i,
    input  logic [VC_W-1:0]                     rd_vc_i,
    output logic [DATA_W-1:0]                   data_o,
    output logic                                rd_valid_o,
    output logic [VC_NUM-1:0]                   full_o,
    output logic [VC_NUM-1:0]                   empty_o,
    output logic [VC_NUM-1:0]                   a_full_o,
    output logic [VC_NUM-1:0]                   a_empty_o,
    output logic [VC_NUM*(FIFO_DEPTH_W+1)-1:0]  count_o,
    output logic [VC_NUM-1:0]                   overflow_o,
    output logic [VC_NUM-1:0]                   underflow_o,
    input  logic                                err_clr_i
);

    localparam int c_DEPTH = 1 << FIFO_DEPTH_W;
    localparam int c_CNT_W = FIFO_DEPTH_W + 1;
    // Instance tag kept visible for debug tooling that inspects parameters.
    localparam int c_ID    = ID;

    logic [VC_NUM-1:0]  w_full;
    logic [VC_NUM-1:0]  w_empty;
    logic [VC_NUM-1:0]  w_rd_acc;
    logic [DATA_W-1:0]  w_head [VC_NUM];
    logic [DATA_W-1:0]  w_sel_head;
    logic               w_sel_valid;

    // ------------------------------------------------------------------------
    // Per-VC queue: storage, pointers, count, status and sticky error flags.
    // An index that matches no generated VC (out of range) hits nothing, so
    // such requests are silently ignored without touching any state.
    // ------------------------------------------------------------------------
    generate
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            logic [DATA_W-1:0]       r_mem [c_DEPTH];
            logic [FIFO_DEPTH_W-1:0] r_wr_ptr;
            logic [FIFO_DEPTH_W-1:0] r_rd_ptr;
            logic [c_CNT_W-1:0]      r_count;
            logic                    r_ovf;
            logic                    r_unf;
            logic                    w_wr_hit;
            logic                    w_rd_hit;
            logic                    w_wr_acc;

            assign w_wr_hit    = wr_en_i && (wr_vc_i == VC_W'(v));
            assign w_rd_hit    = rd_en_i && (rd_vc_i == VC_W'(v));
            // No bypass: a read on an empty queue is refused even when a
            // write lands in the same cycle.
            assign w_rd_acc[v] = w_rd_hit && !w_empty[v];
            // A full queue still takes a write when it is drained that cycle.
            assign w_wr_acc    = w_wr_hit && (!w_full[v] || w_rd_acc[v]);

            assign w_full[v]   = (r_count == c_CNT_W'(c_DEPTH));
            assign w_empty[v]  = (r_count == '0);
            assign full_o[v]   = w_full[v];
            assign empty_o[v]  = w_empty[v];
            assign a_full_o[v] = (r_count >= c_CNT_W'(ALMOST_FULL_THRESHOLD));
            assign a_empty_o[v]= (r_count <= c_CNT_W'(ALMOST_EMPTY_THRESHOLD));
            assign overflow_o[v]  = r_ovf;
            assign underflow_o[v] = r_unf;
            assign count_o[v*c_CNT_W +: c_CNT_W] = r_count;
            assign w_head[v]   = r_mem[r_rd_ptr];

            // Flit storage; intentionally not reset, only pointers matter.
            always_ff @(posedge clk_i) begin
                if (w_wr_acc) begin
                    r_mem[r_wr_ptr] <= data_i;
                end
            end

            // Pointer and occupancy bookkeeping; pointers wrap naturally.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_wr_acc) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_rd_acc[v]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_wr_acc, w_rd_acc[v]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Sticky error flags; a clear request beats a same-cycle set.
            always_ff @(posedge clk_i) begin
                if (rst_i || err_clr_i) begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end else begin
                    if (w_wr_hit && !w_wr_acc) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_rd_hit && !w_rd_acc[v]) begin
                        r_unf <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Head word and availability of the VC currently addressed by rd_vc_i.
    always_comb begin
        w_sel_head  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (rd_vc_i == VC_W'(i)) begin
                w_sel_head  = w_head[i];
                w_sel_valid = !w_empty[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data path: either show the head word directly or register it.
    // ------------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            assign data_o     = w_sel_head;
            assign rd_valid_o = w_sel_valid;
        end else begin : g_reg
            logic [DATA_W-1:0] r_data;
            logic              r_valid;

            // Capture the popped word; data holds its last value when idle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (|w_rd_acc) begin
                    r_data  <= w_sel_head;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            assign data_o     = r_data;
            assign rd_valid_o = r_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_fifo
//  Description : Self-checking bench for vc_fifo; one registered-output
//                instance and one first-word-fall-through instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vc_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output instance signals
    logic        rst, wr_en, rd_en, clr;
    logic [0:0]  wr_vc, rd_vc;
    logic [7:0]  din, dout;
    logic        valid;
    logic [1:0]  full, empty, afull, aempty, ovf, unf;
    logic [5:0]  count;

    // FWFT instance signals
    logic        b_rst, b_wr_en, b_rd_en, b_clr;
    logic [0:0]  b_wr_vc, b_rd_vc;
    logic [7:0]  b_din, b_dout;
    logic        b_valid;
    logic [1:0]  b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic [5:0]  b_count;

    vc_fifo #(.DATA_W(8), .FIFO_DEPTH_W(2), .VC_NUM(2), .FWFT(0),
              .ALMOST_EMPTY_THRESHOLD(1), .ALMOST_FULL_THRESHOLD(3), .ID(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_vc_i(wr_vc), .data_i(din),
        .rd_en_i(rd_en), .rd_vc_i(rd_vc), .data_o(dout), .rd_valid_o(valid),
        .full_o(full), .empty_o(empty), .a_full_o(afull), .a_empty_o(aempty),
        .count_o(count), .overflow_o(ovf), .underflow_o(unf), .err_clr_i(clr)
    );

    vc_fifo #(.DATA_W(8), .FIFO_DEPTH_W(2), .VC_NUM(2), .FWFT(1),
              .ALMOST_EMPTY_THRESHOLD(1), .ALMOST_FULL_THRESHOLD(3), .ID(1)) u_dut1 (
        .clk_i(clk), .rst_i(b_rst), .wr_en_i(b_wr_en), .wr_vc_i(b_wr_vc), .data_i(b_din),
        .rd_en_i(b_rd_en), .rd_vc_i(b_rd_vc), .data_o(b_dout), .rd_valid_o(b_valid),
        .full_o(b_full), .empty_o(b_empty), .a_full_o(b_afull), .a_empty_o(b_aempty),
        .count_o(b_count), .overflow_o(b_ovf), .underflow_o(b_unf), .err_clr_i(b_clr)
    );

    typedef struct packed {
        logic       wr_en;
        logic       wr_vc;
        logic [7:0] din;
        logic       rd_en;
        logic       rd_vc;
        logic       clr;
        logic [7:0] e_data;
        logic       e_valid;
        logic [1:0] e_full;
        logic [1:0] e_empty;
        logic [1:0] e_afull;
        logic [1:0] e_aempty;
        logic [5:0] e_count;   // {count VC1, count VC0}
        logic [1:0] e_ovf;
        logic [1:0] e_unf;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;

    initial begin
        // wr  vc din    rd vc clr  data  v  full   empty  afull  aempty count     ovf    unf
        vecs[0]  = '{1'b1,1'b1,8'h11,1'b0,1'b0,1'b0, 8'h00,1'b0,2'b00,2'b01,2'b00,2'b11,6'o10,2'b00,2'b00};
        vecs[1]  = '{1'b1,1'b1,8'h22,1'b0,1'b0,1'b0, 8'h00,1'b0,2'b00,2'b01,2'b00,2'b01,6'o20,2'b00,2'b00};
        vecs[2]  = '{1'b1,1'b1,8'h33,1'b0,1'b0,1'b0, 8'h00,1'b0,2'b00,2'b01,2'b10,2'b01,6'o30,2'b00,2'b00};
        vecs[3]  = '{1'b1,1'b1,8'h44,1'b0,1'b0,1'b0, 8'h00,1'b0,2'b10,2'b01,2'b10,2'b01,6'o40,2'b00,2'b00};
        vecs[4]  = '{1'b1,1'b1,8'h55,1'b0,1'b0,1'b0, 8'h00,1'b0,2'b10,2'b01,2'b10,2'b01,6'o40,2'b10,2'b00};
        vecs[5]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 8'h11,1'b1,2'b00,2'b01,2'b10,2'b01,6'o30,2'b10,2'b00};
        vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 8'h22,1'b1,2'b00,2'b01,2'b00,2'b01,6'o20,2'b10,2'b00};
        vecs[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 8'h33,1'b1,2'b00,2'b01,2'b00,2'b11,6'o10,2'b10,2'b00};
        vecs[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1, 8'h44,1'b1,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};
        vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 8'h44,1'b0,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};
        vecs[10] = '{1'b1,1'b0,8'hA0,1'b0,1'b0,1'b0, 8'h44,1'b0,2'b00,2'b10,2'b00,2'b11,6'o01,2'b00,2'b00};
        vecs[11] = '{1'b1,1'b0,8'hA1,1'b0,1'b0,1'b0, 8'h44,1'b0,2'b00,2'b10,2'b00,2'b10,6'o02,2'b00,2'b00};
        vecs[12] = '{1'b1,1'b1,8'hB0,1'b0,1'b0,1'b0, 8'h44,1'b0,2'b00,2'b00,2'b00,2'b10,6'o12,2'b00,2'b00};
        vecs[13] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 8'hB0,1'b1,2'b00,2'b10,2'b00,2'b10,6'o02,2'b00,2'b00};
        vecs[14] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 8'hA0,1'b1,2'b00,2'b10,2'b00,2'b11,6'o01,2'b00,2'b00};
        vecs[15] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 8'hA1,1'b1,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};
        vecs[16] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 8'hA1,1'b0,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b01};
        vecs[17] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 8'hA1,1'b0,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b01};
        vecs[18] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b1, 8'hA1,1'b0,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};
        vecs[19] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1, 8'hA1,1'b0,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};
        vecs[20] = '{1'b1,1'b0,8'h77,1'b1,1'b0,1'b0, 8'hA1,1'b0,2'b00,2'b10,2'b00,2'b11,6'o01,2'b00,2'b01};
        vecs[21] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1, 8'h77,1'b1,2'b00,2'b11,2'b00,2'b11,6'o00,2'b00,2'b00};

        rst = 1'b1; wr_en = 0; rd_en = 0; clr = 0; wr_vc = 0; rd_vc = 0; din = 0;
        b_rst = 1'b1; b_wr_en = 0; b_rd_en = 0; b_clr = 0; b_wr_vc = 0; b_rd_vc = 0; b_din = 0;
        tick(); tick();
        rst = 1'b0; b_rst = 1'b0;
        tick();

        // Reset then idle
        chk("rst_empty",  32'(empty),  32'h3);
        chk("rst_full",   32'(full),   32'h0);
        chk("rst_count",  32'(count),  32'h0);
        chk("rst_aempty", 32'(aempty), 32'h3);
        chk("rst_afull",  32'(afull),  32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_data",   32'(dout),   32'h0);
        chk("rst_errs",   32'({ovf, unf}), 32'h0);

        // Directed vector table on the registered-output instance
        for (int i = 0; i < NVEC; i++) begin
            wr_en = vecs[i].wr_en; wr_vc = vecs[i].wr_vc; din = vecs[i].din;
            rd_en = vecs[i].rd_en; rd_vc = vecs[i].rd_vc; clr = vecs[i].clr;
            tick();
            chk($sformatf("v%0d_data", i),  32'(dout),  32'(vecs[i].e_data));
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_flags", i), 32'({full, empty, afull, aempty}),
                32'({vecs[i].e_full, vecs[i].e_empty, vecs[i].e_afull, vecs[i].e_aempty}));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_errs", i),  32'({ovf, unf}), 32'({vecs[i].e_ovf, vecs[i].e_unf}));
        end
        wr_en = 0; rd_en = 0; clr = 0;

        // Fill VC0, then simultaneous write+read on the full queue
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_vc = 0; din = 8'hC0 + 8'(i); q.push_back(din);
            tick();
        end
        wr_en = 0;
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'o04);
        wr_en = 1; wr_vc = 0; din = 8'h99; rd_en = 1; rd_vc = 0;
        exp_d = q.pop_front(); q.push_back(8'h99);
        tick();
        chk("fullrw_data",  32'(dout),  32'(exp_d));
        chk("fullrw_valid", 32'(valid), 32'h1);
        chk("fullrw_count", 32'(count), 32'o04);
        chk("fullrw_ovf",   32'(ovf),   32'h0);

        // Wrap: push/pop pairs on a full queue keep FIFO order
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; wr_vc = 0; din = 8'hD0 + 8'(i); rd_en = 1; rd_vc = 0;
            exp_d = q.pop_front(); q.push_back(din);
            tick();
            chk($sformatf("wrap%0d_data", i), 32'(dout), 32'(exp_d));
        end
        wr_en = 0; rd_en = 0;
        chk("wrap_count", 32'(count), 32'o04);
        chk("wrap_ovf",   32'(ovf),   32'h0);

        // Drain a couple and confirm order after wrapping
        for (int i = 0; i < 2; i++) begin
            rd_en = 1; rd_vc = 0; exp_d = q.pop_front();
            tick();
            chk($sformatf("drain%0d_data", i), 32'(dout), 32'(exp_d));
        end
        rd_en = 0;

        // Reset mid-operation with entries in both VCs
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_vc = 1; din = 8'hE0 + 8'(i);
            tick();
        end
        wr_en = 0;
        chk("pre_rst_count", 32'(count), 32'o32);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_empty", 32'(empty), 32'h3);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_data",  32'(dout),  32'h0);

        // FWFT instance: word shows up the cycle after the write
        b_wr_en = 1; b_wr_vc = 0; b_din = 8'h5A;
        tick();
        b_wr_en = 0; b_rd_vc = 0;
        #1;
        chk("fwft_data",  32'(b_dout),  32'h5A);
        chk("fwft_valid", 32'(b_valid), 32'h1);
        b_rd_vc = 1;
        #1;
        chk("fwft_vc1_valid", 32'(b_valid), 32'h0);
        b_rd_vc = 0; b_rd_en = 1;
        tick();
        b_rd_en = 0;
        #1;
        chk("fwft_pop_valid", 32'(b_valid), 32'h0);
        chk("fwft_pop_empty", 32'(b_empty), 32'h3);
        chk("fwft_unf",       32'(b_unf),   32'h0);

        // FWFT instance: reset with three entries in VC1
        for (int i = 0; i < 3; i++) begin
            b_wr_en = 1; b_wr_vc = 1; b_din = 8'h60 + 8'(i);
            tick();
        end
        b_wr_en = 0; b_rd_vc = 1;
        #1;
        chk("fwft_vc1_head",  32'(b_dout),  32'h60);
        chk("fwft_vc1_count", 32'(b_count), 32'o30);
        b_rst = 1;
        tick();
        b_rst = 0;
        chk("fwft_rst_empty", 32'(b_empty), 32'h3);
        chk("fwft_rst_valid", 32'(b_valid), 32'h0);
        chk("fwft_rst_count", 32'(b_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Multi-channel (virtual-channel) circular FIFO for NoC router input ports, the successor to the single-channel circular FIFO. Provides VC_NUM independent queues of 2**FIFO_DEPTH_W entries in one block, with all entries usable and per-channel fill counts. Offers selectable registered-output or first-word-fall-through read mode and sticky per-channel error flags. Written by the upstream link, read by the router's switch allocator / crossbar.

Parameters:
DATA_W, 8, flit width in bits
FIFO_DEPTH_W, 2, log2 of per-VC depth; DEPTH = 2**FIFO_DEPTH_W, all DEPTH entries usable
VC_NUM, 2, number of virtual channels (>=1, need not be a power of 2)
VC_W, $clog2(VC_NUM) (min 1), VC index width
FWFT, 0, 0 = registered read data, 1 = first-word-fall-through
ALMOST_EMPTY_THRESHOLD, 1, a_empty when count <= value
ALMOST_FULL_THRESHOLD, 3, a_full when count >= value; must be <= DEPTH
ID, 0, instance identifier for debug prints only

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
wr_en_i  in  1  write request
wr_vc_i  in  VC_W  target VC of write
data_i  in  DATA_W  write data
rd_en_i  in  1  read request
rd_vc_i  in  VC_W  source VC of read
data_o  out  DATA_W  read data
rd_valid_o  out  1  data_o valid
full_o  out  VC_NUM  per-VC full
empty_o  out  VC_NUM  per-VC empty
a_full_o  out  VC_NUM  per-VC almost full
a_empty_o  out  VC_NUM  per-VC almost empty
count_o  out  VC_NUM*(FIFO_DEPTH_W+1)  per-VC occupancy, VC0 in LSBs
overflow_o  out  VC_NUM  sticky per-VC overflow
underflow_o  out  VC_NUM  sticky per-VC underflow
err_clr_i  in  1  clears all sticky flags

Behaviour:
- Per VC: wr_ptr, rd_ptr (FIFO_DEPTH_W bits, natural wrap DEPTH-1 -> 0), count (FIFO_DEPTH_W+1 bits). full = count==DEPTH; empty = count==0; flags combinational from count.
- Reset (rst_i=1 at clock edge): all pointers/counts 0, data_o 0, rd_valid_o 0, overflow/underflow 0; storage array not reset. Reset mid-operation discards all contents; empty_o all-ones the cycle after.
- Read accepted: rd_en_i && rd_vc_i < VC_NUM && !empty[rd_vc_i]. rd_ptr++ , count--.
- Write accepted: wr_en_i && wr_vc_i < VC_NUM && (!full[wr_vc_i] || read accepted same cycle on same VC). Stores at wr_ptr, wr_ptr++, count++.
- Simultaneous accepted read+write on same VC: count unchanged, both pointers advance. Different VCs: independent.
- Write to empty VC with read of same VC same cycle: read rejected (no bypass), underflow set; write accepted.
- Rejected write on full VC: data dropped, overflow_o[vc] <= 1. Rejected read on empty VC: underflow_o[vc] <= 1. Flags hold until err_clr_i (clear wins over a same-cycle set) or reset.
- Out-of-range VC index: request ignored, no flag, no state change.
- FWFT=0: on accepted read, data_o <= head entry, rd_valid_o <= 1 next cycle (latency 1); otherwise rd_valid_o <= 0, data_o holds last value.
- FWFT=1: data_o = head entry of rd_vc_i combinationally, rd_valid_o = !empty[rd_vc_i] (0 for out-of-range index); rd_en_i pops the shown word.
- a_full/a_empty are comparisons on full-width count (no truncation at count==DEPTH).

Test Plan:
- Reset then idle: empty_o=2'b11, full_o=0, count_o=0, a_empty_o=2'b11, rd_valid_o=0, data_o=0.
- FWFT=0: write 0x11,0x22,0x33,0x44 to VC1 -> full_o=2'b10, count VC1=4, a_full_o[1]=1; 5th write 0x55 -> overflow_o=2'b10, count stays 4; 4 reads -> data_o 0x11..0x44 each one cycle after rd_en_i, rd_valid_o pulses 4 cycles.
- Interleave: VC0 gets 0xA0,0xA1, VC1 gets 0xB0; read VC1 then VC0 twice -> 0xB0,0xA0,0xA1; no cross-VC corruption.
- Full VC0 with simultaneous write 0x99 and read -> read returns oldest, write accepted, count stays 4, no overflow; wrap: 10 push/pop pairs preserve order.
- Read empty VC0 -> underflow_o=2'b01, held across cycles; err_clr_i pulse -> 0.
- FWFT=1: write 0x5A to VC0 -> next cycle data_o=0x5A, rd_valid_o=1 with rd_vc_i=0; rd_en_i -> rd_valid_o=0 next cycle. Assert rst_i with 3 entries in VC1 -> empty next cycle.
